// File: rtl/fu_wb_scheduler_pkg.sv
// Shared types for the writeback scheduler: FU ids, default latencies,
// reservation-table entry and the FU-to-latency mapping.
package fu_sched_pkg;

   localparam logic [2:0] FU_NONE = 3'd0;
   localparam logic [2:0] FU_ALU  = 3'd1;
   localparam logic [2:0] FU_MEM  = 3'd2;
   localparam logic [2:0] FU_MUL  = 3'd3;
   localparam logic [2:0] FU_DIV  = 3'd4;
   localparam logic [2:0] FU_JUMP = 3'd5;

   localparam int unsigned DEF_LAT_ALU  = 1;
   localparam int unsigned DEF_LAT_MEM  = 2;
   localparam int unsigned DEF_LAT_MUL  = 7;
   localparam int unsigned DEF_LAT_DIV  = 24;
   localparam int unsigned DEF_LAT_JUMP = 2;

   typedef struct packed {
      logic       valid;
      logic [2:0] fu;
      logic [4:0] rd;
      logic       wen;
   } slot_t;

   localparam int SLOT_W = $bits(slot_t);

   // Latencies are passed in so parameter overrides on the top are honoured.
   function automatic int unsigned fu_lat(input logic [2:0] fu,
                                          input int unsigned l_alu, input int unsigned l_mem,
                                          input int unsigned l_mul, input int unsigned l_div,
                                          input int unsigned l_jump);
      case (fu)
         FU_ALU:  return l_alu;
         FU_MEM:  return l_mem;
         FU_MUL:  return l_mul;
         FU_DIV:  return l_div;
         FU_JUMP: return l_jump;
         default: return 0;
      endcase
   endfunction

   function automatic logic fu_is_real(input logic [2:0] fu);
      return (fu >= FU_ALU) && (fu <= FU_JUMP);
   endfunction

endpackage

// File: rtl/fu_wb_scheduler_wb_slot_table.sv
// Writeback reservation table: shifts toward slot[0] every cycle, with one
// insert port that overrides the shifted value at its index.
module wb_slot_table
   import fu_sched_pkg::*;
#(
   parameter int unsigned DEPTH = 32,
   localparam int IW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ins_en,
   input  logic [IW-1:0] ins_idx,
   input  slot_t         ins_entry,
   input  logic [IW-1:0] rd_idx,
   output slot_t         slot0,
   output slot_t         slotk
);

   slot_t [DEPTH-1:0] slots;
   slot_t [DEPTH-1:0] slots_nxt;

   always_comb begin
      slots_nxt = slots >> SLOT_W;
      if (ins_en) slots_nxt[ins_idx] = ins_entry;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) slots <= '0;
      else      slots <= slots_nxt;
   end

   assign slot0 = slots[0];
   assign slotk = slots[rd_idx];

endmodule

// File: rtl/fu_wb_scheduler.sv
// Issue-stage scheduler for five fixed-latency FUs sharing one writeback port.
// Optional perf counters under FU_PERF_CNT_EN.
module fu_wb_scheduler
   import fu_sched_pkg::*;
#(
   parameter int unsigned DEPTH    = 32,
   parameter int unsigned LAT_ALU  = DEF_LAT_ALU,
   parameter int unsigned LAT_MEM  = DEF_LAT_MEM,
   parameter int unsigned LAT_MUL  = DEF_LAT_MUL,
   parameter int unsigned LAT_DIV  = DEF_LAT_DIV,
   parameter int unsigned LAT_JUMP = DEF_LAT_JUMP
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        issue_valid,
   input  logic [2:0]  issue_fu,
   input  logic [4:0]  issue_rd,
   input  logic        issue_wen,
   input  logic [4:0]  issue_rs1,
   input  logic [4:0]  issue_rs2,
   input  logic        issue_rs1_used,
   input  logic        issue_rs2_used,
   input  logic        flush,
   output logic        issue_grant,
   output logic        stall,
   output logic        haz_raw,
   output logic        haz_waw,
   output logic        haz_struct,
   output logic        wb_valid,
   output logic [2:0]  wb_fu,
   output logic [4:0]  wb_rd,
   output logic        wb_wen,
   output logic [31:0] reg_busy,
   output logic [5:0]  fu_busy
`ifdef FU_PERF_CNT_EN
   ,
   output logic [31:0] cnt_grant,
   output logic [31:0] cnt_raw,
   output logic [31:0] cnt_waw,
   output logic [31:0] cnt_struct
`endif
);

   localparam int IW = $clog2(DEPTH);

   logic [IW-1:0] look_idx, ins_idx;
   logic          is_real, fu_sel_busy, ins_en;
   slot_t         slot0, slotk, new_entry;
   logic [31:0]   rb_nxt;
   logic [5:0]    fb_nxt;

   always_comb begin
      look_idx = IW'(fu_lat(issue_fu, LAT_ALU, LAT_MEM, LAT_MUL, LAT_DIV, LAT_JUMP));
      ins_idx  = look_idx - IW'(1);
   end

   wb_slot_table #(.DEPTH(DEPTH)) u_tbl (
      .clk       (clk),
      .rst       (rst),
      .ins_en    (ins_en),
      .ins_idx   (ins_idx),
      .ins_entry (new_entry),
      .rd_idx    (look_idx),
      .slot0     (slot0),
      .slotk     (slotk)
   );

   always_comb begin
      fu_sel_busy = 1'b0;
      for (int i = 1; i < 6; i++)
         if (issue_fu == 3'(i)) fu_sel_busy = fu_busy[i];
   end

   assign is_real    = fu_is_real(issue_fu);
   assign haz_raw    = (issue_rs1_used && issue_rs1 != 5'd0 && reg_busy[issue_rs1]) ||
                       (issue_rs2_used && issue_rs2 != 5'd0 && reg_busy[issue_rs2]);
   assign haz_waw    = issue_wen && issue_rd != 5'd0 && reg_busy[issue_rd];
   assign haz_struct = is_real && (fu_sel_busy || slotk.valid);

   // Non-table FU ids only wait for their sources; they never write back.
   assign issue_grant = rst && issue_valid && !flush && !haz_raw &&
                        !(is_real && (haz_waw || haz_struct));
   assign stall       = issue_valid && !issue_grant && !flush;
   assign ins_en      = issue_grant && is_real;

   always_comb begin
      new_entry.valid = 1'b1;
      new_entry.fu    = issue_fu;
      new_entry.rd    = issue_rd;
      new_entry.wen   = issue_wen && issue_rd != 5'd0;
   end

   assign wb_valid = slot0.valid;
   assign wb_fu    = slot0.fu;
   assign wb_rd    = slot0.rd;
   assign wb_wen   = slot0.wen;

   // Clear on retire first, then set on grant so a same-edge grant wins.
   always_comb begin
      fb_nxt = fu_busy;
      rb_nxt = reg_busy;
      for (int i = 1; i < 6; i++) begin
         if (slot0.valid && slot0.fu == 3'(i)) fb_nxt[i] = 1'b0;
         if (ins_en && issue_fu == 3'(i))      fb_nxt[i] = 1'b1;
      end
      fb_nxt[0] = 1'b0;
      if (slot0.valid && slot0.wen) rb_nxt[slot0.rd] = 1'b0;
      if (ins_en && new_entry.wen)  rb_nxt[issue_rd] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fu_busy  <= '0;
         reg_busy <= '0;
      end else begin
         fu_busy  <= fb_nxt;
         reg_busy <= rb_nxt;
      end
   end

`ifdef FU_PERF_CNT_EN
   logic inc_raw, inc_waw, inc_struct;

   assign inc_raw    = stall && haz_raw;
   assign inc_waw    = stall && !haz_raw && haz_waw;
   assign inc_struct = stall && !haz_raw && !haz_waw && haz_struct;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_grant  <= '0;
         cnt_raw    <= '0;
         cnt_waw    <= '0;
         cnt_struct <= '0;
      end else begin
         if (issue_grant && cnt_grant  != '1) cnt_grant  <= cnt_grant  + 32'd1;
         if (inc_raw     && cnt_raw    != '1) cnt_raw    <= cnt_raw    + 32'd1;
         if (inc_waw     && cnt_waw    != '1) cnt_waw    <= cnt_waw    + 32'd1;
         if (inc_struct  && cnt_struct != '1) cnt_struct <= cnt_struct + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fu_wb_scheduler.sv
// Directed bench for fu_wb_scheduler (default build, counters absent).
module tb_fu_wb_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        issue_valid = 1'b0;
   logic [2:0]  issue_fu = '0;
   logic [4:0]  issue_rd = '0;
   logic        issue_wen = 1'b0;
   logic [4:0]  issue_rs1 = '0, issue_rs2 = '0;
   logic        issue_rs1_used = 1'b0, issue_rs2_used = 1'b0;
   logic        flush = 1'b0;
   logic        issue_grant, stall, haz_raw, haz_waw, haz_struct;
   logic        wb_valid, wb_wen;
   logic [2:0]  wb_fu;
   logic [4:0]  wb_rd;
   logic [31:0] reg_busy;
   logic [5:0]  fu_busy;

   int n_chk = 0;
   int n_err = 0;
   int n_stall;

   fu_wb_scheduler dut (
      .clk(clk), .rst(rst),
      .issue_valid(issue_valid), .issue_fu(issue_fu), .issue_rd(issue_rd),
      .issue_wen(issue_wen), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
      .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
      .flush(flush), .issue_grant(issue_grant), .stall(stall),
      .haz_raw(haz_raw), .haz_waw(haz_waw), .haz_struct(haz_struct),
      .wb_valid(wb_valid), .wb_fu(wb_fu), .wb_rd(wb_rd), .wb_wen(wb_wen),
      .reg_busy(reg_busy), .fu_busy(fu_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got %0h want %0h", tag, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [2:0] fu, input logic [4:0] rd,
                        input logic wen, input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2, input logic fl);
      issue_valid = v;  issue_fu = fu;  issue_rd = rd;  issue_wen = wen;
      issue_rs1 = r1;   issue_rs1_used = u1;
      issue_rs2 = r2;   issue_rs2_used = u2;
      flush = fl;
      #1;
   endtask

   // Advance to the next cycle; inputs return to idle.
   task automatic tick();
      @(posedge clk);
      #1;
      drive(0, 3'd0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   initial begin
      // reset state with a valid instruction presented
      #1 rst = 1'b0;
      drive(1, 3'd1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0);
      chk("rst_grant", 32'(issue_grant), 0);
      chk("rst_stall", 32'(stall), 1);
      chk("rst_wbv", 32'(wb_valid), 0);
      chk("rst_regbusy", reg_busy, 0);
      chk("rst_fubusy", 32'(fu_busy), 0);
      chk("rst_haz", {29'd0, haz_raw, haz_waw, haz_struct}, 0);
      @(negedge clk); rst = 1'b1;
      tick();

      // ADD x5 at cycle 10
      idle(10);
      drive(1, 3'd1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0);
      chk("alu_grant", 32'(issue_grant), 1);
      tick();
      chk("alu_wb", {25'd0, wb_valid, wb_fu, wb_rd[2:0]}, {25'd0, 1'b1, 3'd1, 3'd5});
      chk("alu_wbrd", 32'(wb_rd), 5);
      chk("alu_busy_wb", reg_busy, 32'h20);
      tick();
      chk("alu_clear", reg_busy, 0);
      chk("alu_wbv_off", 32'(wb_valid), 0);

      // ALU back-to-back: non-pipelined, re-issue at t+L+1
      drive(1, 3'd1, 5'd1, 1, 5'd0, 0, 5'd0, 0, 0);
      tick();
      drive(1, 3'd1, 5'd2, 1, 5'd0, 0, 5'd0, 0, 0);
      chk("alu_fu_struct", 32'(haz_struct), 1);
      chk("alu_fu_stall", 32'(stall), 1);
      tick();
      drive(1, 3'd1, 5'd2, 1, 5'd0, 0, 5'd0, 0, 0);
      chk("alu_reissue", 32'(issue_grant), 1);
      idle(3);

      // MUL x3 at 0, ADD x4 at 5
      drive(1, 3'd3, 5'd3, 1, 5'd0, 0, 5'd0, 0, 0);
      chk("mul_grant", 32'(issue_grant), 1);
      tick();
      chk("mul_fubusy", 32'(fu_busy), 32'h08);
      idle(4);
      drive(1, 3'd1, 5'd4, 1, 5'd0, 0, 5'd0, 0, 0);
      chk("add5_grant", 32'(issue_grant), 1);
      tick();
      chk("c6_wb", {24'd0, wb_valid, wb_fu, wb_rd}, {24'd0, 1'b1, 3'd1, 5'd4});
      tick();
      chk("c7_wb", {24'd0, wb_valid, wb_fu, wb_rd}, {24'd0, 1'b1, 3'd3, 5'd3});
      tick();
      chk("c8_idle", reg_busy | 32'(fu_busy), 0);
      idle(2);

      // DIV x7 then dependent ADD x8 = x7 + x1
      drive(1, 3'd4, 5'd7, 1, 5'd0, 0, 5'd0, 0, 0);
      chk("div_grant", 32'(issue_grant), 1);
      tick();
      n_stall = 0;
      for (int c = 1; c <= 24; c++) begin
         drive(1, 3'd1, 5'd8, 1, 5'd7, 1, 5'd1, 1, 0);
         if (c == 1) chk("div_raw_c1", 32'(haz_raw), 1);
         if (c == 24) chk("div_wb_c24", {24'd0, wb_valid, wb_fu, wb_rd}, {24'd0, 1'b1, 3'd4, 5'd7});
         if (stall && haz_raw && !issue_grant) n_stall++;
         tick();
      end
      chk("div_raw_cycles", 32'(n_stall), 24);
      drive(1, 3'd1, 5'd8, 1, 5'd7, 1, 5'd1, 1, 0);
      chk("div_dep_grant", 32'(issue_grant), 1);
      tick();
      chk("div_dep_wb", {24'd0, wb_valid, wb_fu, wb_rd}, {24'd0, 1'b1, 3'd1, 5'd8});
      idle(2);

      // MUL x9 at 0, MEM x10 at 5 collides with MUL writeback slot
      drive(1, 3'd3, 5'd9, 1, 5'd0, 0, 5'd0, 0, 0);
      tick();
      idle(4);
      drive(1, 3'd2, 5'd10, 1, 5'd0, 0, 5'd0, 0, 0);
      chk("mem_struct", 32'(haz_struct), 1);
      chk("mem_stall", {30'd0, issue_grant, stall}, 32'b01);
      tick();
      drive(1, 3'd2, 5'd10, 1, 5'd0, 0, 5'd0, 0, 0);
      chk("mem_grant6", 32'(issue_grant), 1);
      tick();
      chk("mul9_wb7", {24'd0, wb_valid, wb_fu, wb_rd}, {24'd0, 1'b1, 3'd3, 5'd9});
      tick();
      chk("mem10_wb8", {24'd0, wb_valid, wb_fu, wb_rd}, {24'd0, 1'b1, 3'd2, 5'd10});
      idle(2);

      // WAW and FU-none handling
      drive(1, 3'd5, 5'd6, 1, 5'd0, 0, 5'd0, 0, 0);
      tick();
      drive(1, 3'd3, 5'd6, 1, 5'd0, 0, 5'd0, 0, 0);
      chk("waw_flag", 32'(haz_waw), 1);
      chk("waw_grant", 32'(issue_grant), 0);
      drive(1, 3'd0, 5'd6, 1, 5'd6, 0, 5'd0, 0, 0);
      chk("none_ignores_waw", 32'(issue_grant), 1);
      drive(1, 3'd0, 5'd6, 1, 5'd6, 1, 5'd0, 0, 0);
      chk("none_raw", 32'(issue_grant), 0);
      drive(1, 3'd3, 5'd0, 1, 5'd6, 0, 5'd0, 0, 0);
      chk("x0_no_waw", 32'(haz_waw), 0);
      drive(1, 3'd0, 5'd0, 0, 5'd6, 1, 5'd0, 0, 0);
      tick();
      chk("jump_wb", {24'd0, wb_valid, wb_fu, wb_rd}, {24'd0, 1'b1, 3'd5, 5'd6});
      idle(2);

      // flush squashes ID only; in-flight MEM still writes back
      drive(1, 3'd2, 5'd11, 1, 5'd0, 0, 5'd0, 0, 0);
      tick();
      drive(1, 3'd1, 5'd12, 1, 5'd0, 0, 5'd0, 0, 1);
      chk("flush_grant", {30'd0, issue_grant, stall}, 0);
      tick();
      chk("flush_mem_wb", {24'd0, wb_valid, wb_fu, wb_rd}, {24'd0, 1'b1, 3'd2, 5'd11});
      chk("flush_no_busy", 32'(reg_busy[12]), 0);
      tick();
      chk("flush_no_entry", 32'(wb_valid), 0);
      idle(2);

      // async reset mid-DIV
      drive(1, 3'd4, 5'd7, 1, 5'd0, 0, 5'd0, 0, 0);
      tick();
      idle(11);
      chk("div_inflight", 32'(fu_busy), 32'h10);
      rst = 1'b0;
      #1;
      chk("arst_busy", reg_busy | 32'(fu_busy), 0);
      chk("arst_wbv", 32'(wb_valid), 0);
      @(negedge clk); rst = 1'b1;
      tick();
      drive(1, 3'd1, 5'd13, 1, 5'd7, 1, 5'd0, 0, 0);
      chk("post_rst_grant", {30'd0, issue_grant, stall}, 32'b10);
      tick();
      chk("post_rst_wb", {24'd0, wb_valid, wb_fu, wb_rd}, {24'd0, 1'b1, 3'd1, 5'd13});
      idle(2);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/fu_wb_scheduler.md
Name: fu_wb_scheduler

Overview:
Issue-stage scheduler for the five fixed-latency functional units (ALU, MEM, MUL, DIV, JUMP) that share one register-file writeback port. It keeps a shift-register reservation table of writeback slots, per-FU busy bits and a per-register pending mask. Each cycle it grants or stalls the instruction in ID on RAW, WAW, FU-busy and writeback-slot conflicts. It drives the single writeback select (FU id, rd, write enable) to the WB mux.

Parameters:
DEPTH, 32, reservation-table slots; must exceed the largest latency
LAT_ALU, 1, ALU issue-to-writeback cycles
LAT_MEM, 2, MEM latency
LAT_MUL, 7, MUL latency
LAT_DIV, 24, DIV latency
LAT_JUMP, 2, JUMP latency

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low (asserted when 0)
issue_valid  in  1  ID holds a valid instruction
issue_fu  in  3  target FU: 0 none, 1 ALU, 2 MEM, 3 MUL, 4 DIV, 5 JUMP
issue_rd  in  5  destination register
issue_wen  in  1  instruction writes rd
issue_rs1 / issue_rs2  in  5 each  source registers
issue_rs1_used / issue_rs2_used  in  1 each  source is read
flush  in  1  squash ID this cycle (branch taken)
issue_grant  out  1  instruction dispatched this cycle
stall  out  1  issue_valid & ~issue_grant & ~flush
haz_raw / haz_waw / haz_struct  out  1 each  hazard reasons (combinational)
wb_valid  out  1  slot[0] occupied
wb_fu  out  3  FU id in slot[0]
wb_rd  out  5  rd in slot[0]
wb_wen  out  1  slot[0] writes the register file
reg_busy  out  32  pending-write mask
fu_busy  out  6  per-FU occupied, bit 0 always 0

Behaviour:
- Table entry fields: valid, fu[2:0], rd[4:0], wen. slot[0] is the oldest entry.
- Every edge: slot[i] <= slot[i+1], slot[DEPTH-1] <= empty.
- Grant edge: slot[L-1] <= new entry, overriding the shift into that index. wb_* are driven combinationally from slot[0]. Issue in cycle t with latency L puts the result on wb_* in cycle t+L.
- haz_raw = (rs1_used & rs1!=0 & reg_busy[rs1]) | same for rs2.
- haz_waw = wen & rd!=0 & reg_busy[rd].
- haz_struct = fu_busy[fu] | slot[L].valid, using the pre-shift table.
- issue_grant = issue_valid & ~flush & ~(haz_raw|haz_waw|haz_struct).
- fu 0, 6 or 7: granted when issue_valid & ~flush & ~haz_raw; no table entry, no busy bits set.
- Granted entry: fu_busy[fu] <= 1; reg_busy[rd] <= 1 if wen & rd!=0; entry.wen = wen & rd!=0.
- Retire edge (slot[0].valid): fu_busy[slot0.fu] <= 0; reg_busy[slot0.rd] <= 0 if wb_wen.
- Retire and grant on the same edge: set wins for fu_busy. Same-register retire/set cannot happen because WAW blocks it.
- Busy bits remain set during the writeback cycle; there is no bypass. A dependent instruction issues in cycle t+L+1.
- FUs are non-pipelined: the same FU can re-issue at t+L+1 at the earliest.
- flush blocks grant only; in-flight entries always complete.
- Reset (rst=0, async): table empty, fu_busy=0, reg_busy=0. All outputs read 0, except stall, which follows issue_valid.

Optional Feature:
FU_PERF_CNT_EN:
- Defined: adds 32-bit saturating counters cnt_grant, cnt_raw, cnt_waw, cnt_struct, exposed as outputs. Each hazard counter increments in any cycle its hazard flag causes a stall (priority raw > waw > struct, one counter per cycle). All counters clear on rst.
- Undefined: no counters or ports are present.

Decomposition:
- Package fu_sched_pkg: FU id localparams (FU_NONE..FU_JUMP), default latency constants, the slot entry struct, and a function mapping FU id to latency.
- Sub-module wb_slot_table: DEPTH-entry shift register with insert-at-index and slot[0]/slot[k] read ports. The parent holds the hazard logic, busy bits and grant.

Test Plan:
- ADD x5 (ALU) issued at cycle 10 -> grant at 10; wb_valid=1, wb_rd=5, wb_fu=1 at 11; reg_busy[5] clears after 11.
- MUL x3 issued at cycle 0, then ADD x4 issued at cycle 5 -> ADD wb at 6, MUL wb at 7, no conflict.
- DIV x7 at cycle 0, then ADD x8 = x7 + x1 -> haz_raw stall for cycles 1..24, grant at 25.
- MUL x9 at cycle 0; MEM x10 presented at cycle 5 (L=2, slot 7 = MUL occupied) -> haz_struct at 5, grant at 6.
- flush=1 with a valid ALU instruction -> issue_grant=0, no table change; prior in-flight MEM entry still writes back on schedule.
- rst driven low mid-DIV (slot 12 valid) -> all busy bits and wb_valid immediately 0; first post-reset ADD grants with no stall.
